mux_sync_tx: RTL and testbench



---
 rtl/mux_sync_pkg.sv | 12 +
 rtl/sync_ff_chain.sv | 26 ++
 rtl/mux_sync_tx.sv | 104 ++++++++++
 tb/tb_mux_sync_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sync_pkg.sv
// Shared types and constants for the MUX-synchronizer transmit side.
package mux_sync_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit flop-chain synchronizer with synchronous active-high reset.
module sync_ff_chain
  import mux_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_stages
    $error("sync_ff_chain: SYNC_STAGES must be at least MIN_SYNC_STAGES");
  end

  logic [SYNC_STAGES-1:0] sync_p;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_p <= '0;
    else       sync_p <= {sync_p[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/mux_sync_tx.sv
// Source-side launcher for a MUX synchronizer: holds a word and runs a four-phase req/ack.
// Optional abort timer is compiled in with `define MUX_SYNC_TX_TIMEOUT_EN.
module mux_sync_tx
  import mux_sync_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ctrl_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  err_o
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_sync
    $error("mux_sync_tx: SYNC_STAGES must be at least MIN_SYNC_STAGES");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("mux_sync_tx: TIMEOUT_CYCLES must be positive");
  end

  tx_state_e state, state_nxt;
  logic      ack_s;
  logic      accept;
  logic      ctrl_nxt, done_nxt, err_nxt;
  logic      tmo_hit;
  logic      abort_q;

  sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

`ifdef MUX_SYNC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Hit fires on the edge where the count would reach TIMEOUT_CYCLES.
  assign tmo_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
      abort_q <= 1'b0;
    end else if (accept) begin
      tmo_cnt <= '0;
      abort_q <= 1'b0;
    end else if (state == REQ && tmo_hit) begin
      tmo_cnt <= '0;
      abort_q <= 1'b1;
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign abort_q = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      ctrl_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_o <= ctrl_nxt;
      done_o <= done_nxt;
      err_o  <= err_nxt;
      if (accept) data_o <= data_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)            state_nxt = REQ;
      REQ:     if (ack_s || tmo_hit)  state_nxt = DROP;
      DROP:    if (!ack_s || tmo_hit) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // ready_o is forced low while reset is held so nothing is accepted during reset.
  always_comb begin
    ready_o  = (state == IDLE) && !rst_i;
    accept   = ready_o && valid_i;
    ctrl_nxt = (state_nxt == REQ);
    done_nxt = (state == DROP) && !ack_s && !tmo_hit && !abort_q;
    err_nxt  = tmo_hit;
  end

endmodule

// File: tb/tb_mux_sync_tx.sv
// Directed bench for mux_sync_tx (SYNC_STAGES = 2, TIMEOUT_CYCLES = 16).
module tb_mux_sync_tx;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          ctrl_o;
  logic          ack_i;
  logic          done_o;
  logic          err_o;

  logic loopback;
  logic ack_drv;
  int   n_chk;
  int   n_err;
  int   done_cnt;
  int   done_base;

  assign ack_i = loopback ? ctrl_o : ack_drv;

  always #5 clk = ~clk;

  mux_sync_tx #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .ctrl_o  (ctrl_o),
    .ack_i   (ack_i),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always @(posedge clk) begin
    if (rst_i) done_cnt <= done_cnt;
    else if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    done_cnt = 0;
    loopback = 1'b0;
    ack_drv  = 1'b0;
    rst_i    = 1'b1;
    valid_i  = 1'b1;
    data_i   = 32'hA5A5_A5A5;

    // Reset held for three edges with valid_i high
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_ctrl",  {31'd0, ctrl_o},  32'd0);
      chk("rst_data",  data_o,           32'd0);
      chk("rst_done",  {31'd0, done_o},  32'd0);
      chk("rst_err",   {31'd0, err_o},   32'd0);
    end
    rst_i   = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("rel_ready", {31'd0, ready_o}, 32'd1);

    // Single transfer, ack rises 5 cycles after accept, falls 4 after ctrl drop
    done_base = done_cnt;
    data_i  = 32'hDEAD_BEEF;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("t1_data",  data_o,           32'hDEAD_BEEF);
    chk("t1_ctrl",  {31'd0, ctrl_o},  32'd1);
    chk("t1_ready", {31'd0, ready_o}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t1_req_ctrl", {31'd0, ctrl_o}, 32'd1);
      chk("t1_req_data", data_o, 32'hDEAD_BEEF);
    end
    ack_drv = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_ackr_ctrl", {31'd0, ctrl_o}, (k < 3) ? 32'd1 : 32'd0);
      chk("t1_ackr_data", data_o, 32'hDEAD_BEEF);
      chk("t1_ackr_done", {31'd0, done_o}, 32'd0);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_drop_ctrl",  {31'd0, ctrl_o},  32'd0);
      chk("t1_drop_ready", {31'd0, ready_o}, 32'd0);
    end
    ack_drv = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_fin_done",  {31'd0, done_o},  (k == 3) ? 32'd1 : 32'd0);
      chk("t1_fin_ready", {31'd0, ready_o}, (k == 3) ? 32'd1 : 32'd0);
      chk("t1_fin_data",  data_o, 32'hDEAD_BEEF);
    end
    tick();
    chk("t1_done_off", {31'd0, done_o}, 32'd0);
    chk("t1_done_cnt", done_cnt - done_base, 32'd1);

    // Back-to-back with ack looped from ctrl: done 6 edges after each accept
    done_base = done_cnt;
    loopback  = 1'b1;
    valid_i   = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      data_i = w;
      tick();
      chk("b2b_acc_data", data_o, w);
      chk("b2b_acc_ctrl", {31'd0, ctrl_o}, 32'd1);
      for (int k = 1; k <= 5; k++) begin
        tick();
        chk("b2b_ctrl", {31'd0, ctrl_o}, (k < 3) ? 32'd1 : 32'd0);
        chk("b2b_data", data_o, w);
        chk("b2b_done", {31'd0, done_o}, 32'd0);
      end
      tick();
      chk("b2b_done_pulse", {31'd0, done_o},  32'd1);
      chk("b2b_ready",      {31'd0, ready_o}, 32'd1);
    end
    valid_i = 1'b0;
    tick();
    chk("b2b_idle_ctrl", {31'd0, ctrl_o}, 32'd0);
    chk("b2b_done_cnt",  done_cnt - done_base, 32'd3);
    loopback = 1'b0;

    // valid_i toggling with a new word while in REQ is ignored
    done_base = done_cnt;
    data_i  = 32'h1234_5678;
    valid_i = 1'b1;
    tick();
    data_i = 32'hFFFF_0000;
    for (int k = 0; k < 6; k++) begin
      valid_i = k[0];
      tick();
      chk("ign_data",  data_o, 32'h1234_5678);
      chk("ign_ctrl",  {31'd0, ctrl_o},  32'd1);
      chk("ign_ready", {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    ack_drv = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("ign_ctrl_drop", {31'd0, ctrl_o}, 32'd0);
    ack_drv = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("ign_done", {31'd0, done_o}, 32'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("ign_no_extra_ctrl", {31'd0, ctrl_o}, 32'd0);
    chk("ign_data_kept",     data_o, 32'h1234_5678);
    chk("ign_done_cnt",      done_cnt - done_base, 32'd1);

    // Reset pulsed for one cycle while in REQ
    done_base = done_cnt;
    data_i  = 32'hCAFE_F00D;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("rp_ctrl_up", {31'd0, ctrl_o}, 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    chk("rp_ctrl",  {31'd0, ctrl_o},  32'd0);
    chk("rp_data",  data_o,           32'd0);
    chk("rp_ready", {31'd0, ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rp_ready_rel", {31'd0, ready_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rp_no_done", {31'd0, done_o}, 32'd0);
      chk("rp_idle",    {31'd0, ready_o}, 32'd1);
    end
    chk("rp_done_cnt", done_cnt - done_base, 32'd0);

`ifdef MUX_SYNC_TX_TIMEOUT_EN
    // Ack never arrives: abort 16 edges after accept
    done_base = done_cnt;
    data_i  = 32'h0BAD_F00D;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("tmo_ctrl", {31'd0, ctrl_o}, (k < 16) ? 32'd1 : 32'd0);
      chk("tmo_err",  {31'd0, err_o},  (k == 16) ? 32'd1 : 32'd0);
    end
    tick();
    chk("tmo_ready",    {31'd0, ready_o}, 32'd1);
    chk("tmo_err_off",  {31'd0, err_o},   32'd0);
    chk("tmo_no_done",  {31'd0, done_o},  32'd0);
    tick();
    chk("tmo_done_cnt", done_cnt - done_base, 32'd0);
`else
    // Without the timer the request waits on ack indefinitely
    data_i  = 32'h0BAD_F00D;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("wait_ctrl", {31'd0, ctrl_o}, 32'd1);
      chk("wait_err",  {31'd0, err_o},  32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
